spi_shift_register_n: RTL
=========================

SPI_SHIFT_REGISTER_N -- requirements
Module: spi_shift_register_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, shift register length in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, shift order (1 = MSB out first, 0 = LSB out first).
REQ-003 SHALL have port CLK, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 SHALL have port CLR_N, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port LOAD, input, 1 bit, request to start a frame with P_DATA_IN.
REQ-006 SHALL have port P_DATA_IN, input, WIDTH bits, parallel word to transmit.
REQ-007 SHALL have port S_DATA_IN, input, 1 bit, serial receive bit.
REQ-008 SHALL have port SHIFT_EN, input, 1 bit, one-cycle shift tick from the SPI clock generator.
REQ-009 SHALL have port S_DATA_OUT, output, 1 bit, serial transmit bit.
REQ-010 SHALL have port P_DATA_OUT, output, WIDTH bits, register contents (the received word once DONE is high).
REQ-011 SHALL have port BUSY, output, 1 bit, frame in progress.
REQ-012 SHALL have port DONE, output, 1 bit, one-cycle frame-complete pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE, with a bit counter of $clog2(WIDTH) bits.
REQ-014 In IDLE or DONE, LOAD=1 SHALL load P_DATA_IN into the register, clear the counter and move to SHIFT; SHIFT_EN is ignored in that cycle (load wins).
REQ-015 In IDLE with LOAD=0, the register SHALL hold; SHIFT_EN is ignored.
REQ-016 In SHIFT, each cycle with SHIFT_EN=1 SHALL shift the register one position toward the output end, insert S_DATA_IN at the vacated end, and increment the counter.
REQ-017 MSB_FIRST=1: shift left, S_DATA_IN enters bit 0. MSB_FIRST=0: shift right, S_DATA_IN enters bit WIDTH-1.
REQ-018 S_DATA_OUT SHALL be combinational: register bit WIDTH-1 if MSB_FIRST=1, else bit 0.
REQ-019 In SHIFT, cycles with SHIFT_EN=0 SHALL hold the register and counter; gaps of any length are legal.
REQ-020 The SHIFT_EN tick taken when counter = WIDTH-1 SHALL complete the shift and move to DONE; the counter then wraps to 0.
REQ-021 DONE state SHALL last exactly one cycle, DONE=1 during it, then return to IDLE (or SHIFT if LOAD=1).
REQ-022 BUSY SHALL be 1 exactly while the state is SHIFT.
REQ-023 LOAD in SHIFT SHALL be ignored; the frame continues unaffected.
REQ-024 P_DATA_OUT SHALL always equal the register; it holds the received word from DONE until the next accepted LOAD.

Reset
REQ-025 CLR_N=0 SHALL immediately, without a clock, force state IDLE, register 0, counter 0, BUSY 0, DONE 0, S_DATA_OUT 0, P_DATA_OUT 0 (and OVERRUN 0 when present).
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no DONE pulse; the first LOAD after release SHALL start a clean frame.

Configuration
REQ-027 Macro SPI_SHREG_OVERRUN_EN defined: extra output OVERRUN (1 bit) SHALL be set on any cycle in SHIFT with LOAD=1, stay set (sticky) and clear only on reset or the next accepted LOAD.
REQ-028 Macro SPI_SHREG_OVERRUN_EN undefined: no OVERRUN port and no overrun logic; all other behaviour is unchanged.

Verification
REQ-029 Basic MSB-first frame: WIDTH=8, MSB_FIRST=1, LOAD with 0xA5, S_DATA_IN driven MSB-first with 0x3C, 8 ticks 1 cycle apart. Required: S_DATA_OUT = 1,0,1,0,0,1,0,1 before each tick; DONE high for 1 cycle after the 8th tick; P_DATA_OUT = 0x3C; BUSY high 8 cycles.
REQ-030 LSB-first with gaps: MSB_FIRST=0, LOAD 0x81, S_DATA_IN = 0x5A LSB-first, ticks every 4 cycles. Required: S_DATA_OUT = 1,0,0,0,0,0,0,1; P_DATA_OUT = 0x5A at DONE; no early DONE.
REQ-031 Load priority and back-to-back: LOAD and SHIFT_EN both high in IDLE, then LOAD high again during the DONE cycle. Required: no shift on the load cycle; second frame starts without an IDLE cycle; BUSY low only during DONE.
REQ-032 Reset mid-frame: CLR_N low after 3 ticks of 0xFF. Required: all outputs 0 immediately, no DONE pulse; a following LOAD 0x12 frame completes correctly.
REQ-033 Overrun (macro defined): LOAD pulse at tick 4 of a frame. Required: frame unaffected, OVERRUN=1 sticky through DONE, cleared by the next accepted LOAD. Macro undefined: same stimulus, identical frame result.

Source files
------------

// File: rtl/spi_shift_register_n.sv
// -----------------------------------------------------------------------------
// spi_shift_register_n
//
// Parallel-in / serial-out and serial-in / parallel-out shift register for one
// SPI frame of WIDTH bits. A frame starts when LOAD is accepted in IDLE or DONE.
// It advances one bit on every SHIFT_EN tick and ends with a one-cycle DONE
// state. P_DATA_OUT then holds the word received on S_DATA_IN.
//
// Parameters
//   WIDTH      shift register length in bits (2..32)
//   MSB_FIRST  1: shift left, MSB goes out first; 0: shift right, LSB first
//
// Ports
//   CLK         rising-edge clock
//   CLR_N       asynchronous active-low reset
//   LOAD        start a frame with P_DATA_IN (ignored while a frame runs)
//   P_DATA_IN   word to transmit
//   S_DATA_IN   serial receive bit, inserted at the vacated end on each tick
//   SHIFT_EN    one-cycle shift tick from the SPI clock generator
//   S_DATA_OUT  serial transmit bit (combinational from the register)
//   P_DATA_OUT  register contents; the received word once DONE is high
//   BUSY        high while a frame is in progress
//   DONE        one-cycle frame-complete pulse
//   OVERRUN     (only with SPI_SHREG_OVERRUN_EN) sticky flag: LOAD was seen
//               during a frame; cleared by reset or the next accepted LOAD
//
// Optional feature macro: SPI_SHREG_OVERRUN_EN
// -----------------------------------------------------------------------------
module spi_shift_register_n #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] P_DATA_IN,
    input  logic             S_DATA_IN,
    input  logic             SHIFT_EN,
    output logic             S_DATA_OUT,
    output logic [WIDTH-1:0] P_DATA_OUT,
    output logic             BUSY,
`ifdef SPI_SHREG_OVERRUN_EN
    output logic             DONE,
    output logic             OVERRUN
`else
    output logic             DONE
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] shreg_shifted;
`ifdef SPI_SHREG_OVERRUN_EN
    logic             overrun_q, overrun_d;
`endif

    // The register moves toward the output end; the received bit fills the
    // position that was vacated.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shreg_shifted = {shreg_q[WIDTH-2:0], S_DATA_IN};
        end else begin
            shreg_shifted = {S_DATA_IN, shreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SPI_SHREG_OVERRUN_EN
        overrun_d = overrun_q;
`endif
        unique case (state_q)
            // LOAD takes priority over SHIFT_EN here, and DONE behaves like
            // IDLE so that back-to-back frames need no idle cycle.
            ST_IDLE, ST_DONE: begin
                if (LOAD) begin
                    shreg_d = P_DATA_IN;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef SPI_SHREG_OVERRUN_EN
                    overrun_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // LOAD has no effect on the frame in this state; it only sets the
            // overrun flag when that feature is built in.
            ST_SHIFT: begin
`ifdef SPI_SHREG_OVERRUN_EN
                if (LOAD) begin
                    overrun_d = 1'b1;
                end
`endif
                if (SHIFT_EN) begin
                    shreg_d = shreg_shifted;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            // NOTE: the data register is reset along with the control state,
            // because P_DATA_OUT and S_DATA_OUT must read 0 during reset.
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SPI_SHREG_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SPI_SHREG_OVERRUN_EN
            overrun_q <= overrun_d;
`endif
        end
    end

    // BUSY and DONE are decoded from the state flop, so they are glitch-free.
    assign BUSY       = (state_q == ST_SHIFT);
    assign DONE       = (state_q == ST_DONE);
    assign P_DATA_OUT = shreg_q;
    assign S_DATA_OUT = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef SPI_SHREG_OVERRUN_EN
    assign OVERRUN    = overrun_q;
`endif

endmodule
